conv_line_buffer_scheduler: RTL and testbench
=============================================

Name: conv_line_buffer_scheduler

Overview:
- Sequences a pair of cascaded RAM-based line-delay shift registers that form the 3-row window for 3x3 convolution.
- Counts pixels in a feature-map tile and issues the per-pixel write strobe to the line delays.
- Programs their shift size and flags each cycle in which a complete 3x3 window is present.
- Sits between the feature-fetch stream and the convolution MAC array.

Parameters:
- FEATURE_WIDTH, `FEATURE_WIDTH, width of one feature element; pixel word is FEATURE_WIDTH*2.
- DIM_W, 10, width of all row/column sizes and counters.

Ports:
- system_clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches sizes and begins a tile.
- clear  in  1  synchronous abort to IDLE.
- row_size  in  DIM_W  pixels per row (tile width).
- col_size  in  DIM_W  rows per tile (tile height).
- in_valid  in  1  input pixel valid.
- in_data  in  FEATURE_WIDTH*2  input pixel.
- in_ready  out  1  pixel accepted when in_valid & in_ready.
- out_ready  in  1  MAC array can take a window this cycle.
- sr_wr_en  out  1  write strobe to both line delays.
- sr_wr_data  out  FEATURE_WIDTH*2  pixel written to the first line delay.
- sr_shift_size  out  DIM_W  shift size driven to both line delays.
- window_valid  out  1  3x3 window aligned at the line-delay outputs.
- win_row  out  DIM_W  row index of the window's bottom-right pixel.
- win_col  out  DIM_W  column index of the window's bottom-right pixel.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at tile end.
- cfg_err  out  1  sticky illegal-size flag, cleared by the next legal start.

Behaviour:
- Reset: asynchronous, active-low. Forces state IDLE; all outputs and counters to 0.
- States:
  - IDLE: start -> RUN. Latches eff_w and eff_h. sr_shift_size = eff_w - 2, held constant until the next start.
  - RUN: one grid slot per advance cycle, where advance = out_ready & (pad_slot | in_valid).
    - col counter wraps at eff_w-1; on wrap the row counter increments.
    - After slot (eff_h-1, eff_w-1) -> FLUSH.
  - FLUSH: one cycle, letting the registered window_valid for the last slot drain -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Sizes: eff_w = row_size, eff_h = col_size. The legal range of each is 3..1023.
  - Illegal start: cfg_err=1, stay IDLE, done not pulsed.
- Input handshake:
  - in_ready = (state==RUN) & out_ready & ~pad_slot.
  - sr_wr_en = advance.
  - sr_wr_data = in_data (0 on a pad slot).
  - out_ready low freezes counters and the line delays, with no write.
- Window output:
  - window_valid is registered, 1 cycle after sr_wr_en of a slot with row>=2 and col>=2.
  - win_row/win_col carry that slot's indices.
  - Otherwise window_valid=0 and win_row/win_col hold their previous values.
- Counts: unpadded windows per tile = (eff_h-2)*(eff_w-2).
- start while busy: ignored. clear: the next cycle is IDLE, counters 0, no done pulse; sizes are re-latched on the next start.
- Counter arithmetic is modulo 2^DIM_W. No overflow is possible within the legal range.

Optional Feature:
- CONV_ZERO_PAD_EN.
- Defined:
  - eff_w = row_size+2, eff_h = col_size+2; legal row_size/col_size 1..1021.
  - Border slots (row 0, row eff_h-1, col 0, col eff_w-1) are pad slots: a zero pixel is written with in_ready=0 and no input consumed.
  - Output is "same" size, row_size*col_size windows.
- Undefined:
  - pad_slot is tied 0 and eff_w = row_size.
  - No pad logic is synthesised.

Decomposition:
- Shared package (include file): FSM state encodings (IDLE/RUN/FLUSH/DONE) and constants WIN_K=3 and MIN_DIM=3.
- Sub-module conv_tile_counter: row/col counters with wrap, pad_slot detection and last-slot flag; instantiated once.

Test Plan:
- Reset/idle: rst_n low mid-RUN -> next edge state IDLE, sr_wr_en=0, window_valid=0, done=0.
- Basic tile: row_size=5, col_size=4, in_valid and out_ready held high.
  - sr_shift_size=3, 20 writes, 6 window_valid pulses.
  - First pulse has win_row=2, win_col=2; done 2 cycles after the last write.
- Backpressure: same tile with out_ready toggled 1,0,1,0 -> no write while out_ready=0; total writes 20, windows 6, order unchanged.
- Illegal config: start with row_size=2 -> cfg_err=1, busy=0; a later start with 5x4 clears cfg_err.
- Abort/restart: clear after 7 writes -> IDLE next cycle, no done pulse; a new 4x3 start gives 12 writes and 2 windows.
- CONV_ZERO_PAD_EN, row_size=3, col_size=3:
  - 25 writes, 9 from input and 16 zero.
  - in_ready=0 on all border slots; 9 window_valid pulses.

Source files
------------

// File: rtl/conv_line_buffer_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_line_buffer_scheduler_pkg
// Brief    : Shared types and constants for the 3x3 line-buffer scheduler.
//            Supplies the default pixel element width (FEATURE_WIDTH macro)
//            when the build does not provide one.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef FEATURE_WIDTH
`define FEATURE_WIDTH 8
`endif

package conv_line_buffer_scheduler_pkg;

  // Tile sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } tile_state_t;

  // Convolution kernel edge and the smallest unpadded tile edge
  localparam int WIN_K   = 3;
  localparam int MIN_DIM = 3;

  // Inclusive range test used for tile-size legality
  function automatic logic dim_in_range(input int unsigned v,
                                        input int unsigned lo,
                                        input int unsigned hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv_line_buffer_scheduler_tile_counter.sv
`default_nettype none
// ============================================================================
// Module   : conv_tile_counter
// Brief    : Row/column grid counters for one feature-map tile. Columns wrap
//            at eff_w-1 and bump the row; flags the final slot of the tile.
//            With CONV_ZERO_PAD_EN defined, border slots are reported as
//            pad slots; otherwise pad_slot is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module conv_tile_counter #(
  parameter int DIM_W = 10
) (
  input  logic             system_clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic             advance,
  input  logic [DIM_W-1:0] eff_w,
  input  logic [DIM_W-1:0] eff_h,
  output logic [DIM_W-1:0] row,
  output logic [DIM_W-1:0] col,
  output logic             pad_slot,
  output logic             last_slot
);

  logic [DIM_W-1:0] r_row;
  logic [DIM_W-1:0] r_col;
  logic             w_last_col;
  logic             w_last_row;

  assign w_last_col = (r_col == (eff_w - DIM_W'(1)));
  assign w_last_row = (r_row == (eff_h - DIM_W'(1)));
  assign last_slot  = w_last_col & w_last_row;
  assign row        = r_row;
  assign col        = r_col;

`ifdef CONV_ZERO_PAD_EN
  // Outer ring of the padded grid carries zero pixels
  assign pad_slot = (r_row == '0) | w_last_row | (r_col == '0) | w_last_col;
`else
  assign pad_slot = 1'b0;
`endif

  // Step through the grid one slot per advance; init rewinds to the origin
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (init) begin
      r_row <= '0;
      r_col <= '0;
    end else if (advance) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : (r_row + DIM_W'(1));
      end else begin
        r_col <= r_col + DIM_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/conv_line_buffer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : conv_line_buffer_scheduler
// Brief    : Drives two cascaded line-delay shift registers forming the
//            3-row window for 3x3 convolution. Counts tile pixels, issues
//            the write strobe, programs the shift size and flags cycles in
//            which a full 3x3 window is present at the line-delay outputs.
//            Optional zero padding ("same" output) is enabled by defining
//            the CONV_ZERO_PAD_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module conv_line_buffer_scheduler
  import conv_line_buffer_scheduler_pkg::*;
#(
  parameter int FEATURE_WIDTH = `FEATURE_WIDTH,
  parameter int DIM_W         = 10
) (
  input  logic                       system_clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       clear,
  input  logic [DIM_W-1:0]           row_size,
  input  logic [DIM_W-1:0]           col_size,
  input  logic                       in_valid,
  input  logic [FEATURE_WIDTH*2-1:0] in_data,
  output logic                       in_ready,
  input  logic                       out_ready,
  output logic                       sr_wr_en,
  output logic [FEATURE_WIDTH*2-1:0] sr_wr_data,
  output logic [DIM_W-1:0]           sr_shift_size,
  output logic                       window_valid,
  output logic [DIM_W-1:0]           win_row,
  output logic [DIM_W-1:0]           win_col,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err
);

  localparam int unsigned c_dim_max = (1 << DIM_W) - 1;

  tile_state_t      r_state;
  logic [DIM_W-1:0] r_eff_w;
  logic [DIM_W-1:0] r_eff_h;
  logic [DIM_W-1:0] r_shift_size;
  logic             r_window_valid;
  logic [DIM_W-1:0] r_win_row;
  logic [DIM_W-1:0] r_win_col;
  logic             r_busy;
  logic             r_done;
  logic             r_cfg_err;

  logic [DIM_W-1:0] w_row;
  logic [DIM_W-1:0] w_col;
  logic             w_cnt_pad;
  logic             w_last_slot;
  logic             w_run;
  logic             w_pad_slot;
  logic             w_advance;
  logic             w_size_ok;
  logic             w_start_ok;
  logic             w_cnt_init;
  logic             w_win_slot;
  logic [DIM_W-1:0] w_eff_w_next;
  logic [DIM_W-1:0] w_eff_h_next;

  // Requested sizes translate into the grid actually walked
`ifdef CONV_ZERO_PAD_EN
  assign w_eff_w_next = row_size + DIM_W'(2);
  assign w_eff_h_next = col_size + DIM_W'(2);
  assign w_size_ok    = dim_in_range(32'(row_size), 32'd1, c_dim_max - 32'd2) &&
                        dim_in_range(32'(col_size), 32'd1, c_dim_max - 32'd2);
`else
  assign w_eff_w_next = row_size;
  assign w_eff_h_next = col_size;
  assign w_size_ok    = dim_in_range(32'(row_size), 32'(MIN_DIM), c_dim_max) &&
                        dim_in_range(32'(col_size), 32'(MIN_DIM), c_dim_max);
`endif

  assign w_run      = (r_state == ST_RUN);
  assign w_pad_slot = w_run & w_cnt_pad;
  assign w_advance  = w_run & out_ready & (w_pad_slot | in_valid);
  assign w_start_ok = (r_state == ST_IDLE) & start & w_size_ok & ~clear;
  assign w_cnt_init = clear | w_start_ok;
  assign w_win_slot = (w_row >= DIM_W'(WIN_K - 1)) & (w_col >= DIM_W'(WIN_K - 1));

  assign in_ready      = w_run & out_ready & ~w_pad_slot;
  assign sr_wr_en      = w_advance;
  assign sr_wr_data    = w_pad_slot ? '0 : in_data;
  assign sr_shift_size = r_shift_size;
  assign window_valid  = r_window_valid;
  assign win_row       = r_win_row;
  assign win_col       = r_win_col;
  assign busy          = r_busy;
  assign done          = r_done;
  assign cfg_err       = r_cfg_err;

  conv_tile_counter #(
    .DIM_W (DIM_W)
  ) u_tile_counter (
    .system_clk (system_clk),
    .rst_n      (rst_n),
    .init       (w_cnt_init),
    .advance    (w_advance),
    .eff_w      (r_eff_w),
    .eff_h      (r_eff_h),
    .row        (w_row),
    .col        (w_col),
    .pad_slot   (w_cnt_pad),
    .last_slot  (w_last_slot)
  );

  // Tile sequencer with registered status and window outputs
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_eff_w        <= '0;
      r_eff_h        <= '0;
      r_shift_size   <= '0;
      r_window_valid <= 1'b0;
      r_win_row      <= '0;
      r_win_col      <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_cfg_err      <= 1'b0;
    end else begin
      r_window_valid <= 1'b0;
      r_done         <= 1'b0;
      if (clear) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              if (w_size_ok) begin
                r_eff_w      <= w_eff_w_next;
                r_eff_h      <= w_eff_h_next;
                r_shift_size <= w_eff_w_next - DIM_W'(WIN_K - 1);
                r_cfg_err    <= 1'b0;
                r_busy       <= 1'b1;
                r_state      <= ST_RUN;
              end else begin
                r_cfg_err    <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (w_advance) begin
              // Window is complete once this slot lands in the line delays
              if (w_win_slot) begin
                r_window_valid <= 1'b1;
                r_win_row      <= w_row;
                r_win_col      <= w_col;
              end
              if (w_last_slot) begin
                r_state <= ST_FLUSH;
              end
            end
          end
          ST_FLUSH: begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
          ST_DONE: begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_conv_line_buffer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_line_buffer_scheduler
// Brief    : Scoreboard bench for conv_line_buffer_scheduler. Expected line-
//            delay writes and window indices are queued per tile and popped
//            as the design produces them.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef FEATURE_WIDTH
`define FEATURE_WIDTH 8
`endif

module tb_conv_line_buffer_scheduler;

  localparam int DIM_W = 10;
  localparam int PW    = `FEATURE_WIDTH * 2;
`ifdef CONV_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic             system_clk = 1'b0;
  logic             rst_n      = 1'b0;
  logic             start      = 1'b0;
  logic             clear      = 1'b0;
  logic [DIM_W-1:0] row_size   = '0;
  logic [DIM_W-1:0] col_size   = '0;
  logic             in_valid   = 1'b0;
  logic [PW-1:0]    in_data    = '0;
  logic             in_ready;
  logic             out_ready  = 1'b1;
  logic             sr_wr_en;
  logic [PW-1:0]    sr_wr_data;
  logic [DIM_W-1:0] sr_shift_size;
  logic             window_valid;
  logic [DIM_W-1:0] win_row;
  logic [DIM_W-1:0] win_col;
  logic             busy;
  logic             done;
  logic             cfg_err;

  typedef struct {
    logic [PW-1:0] data;
    bit            pad;
  } wr_t;

  typedef struct {
    int row;
    int col;
  } win_t;

  wr_t  exp_wr[$];
  win_t exp_win[$];

  int n_tests = 0;
  int n_fail  = 0;

  conv_line_buffer_scheduler #(
    .FEATURE_WIDTH (`FEATURE_WIDTH),
    .DIM_W         (DIM_W)
  ) dut (
    .system_clk    (system_clk),
    .rst_n         (rst_n),
    .start         (start),
    .clear         (clear),
    .row_size      (row_size),
    .col_size      (col_size),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .out_ready     (out_ready),
    .sr_wr_en      (sr_wr_en),
    .sr_wr_data    (sr_wr_data),
    .sr_shift_size (sr_shift_size),
    .window_valid  (window_valid),
    .win_row       (win_row),
    .win_col       (win_col),
    .busy          (busy),
    .done          (done),
    .cfg_err       (cfg_err)
  );

  always #5 system_clk = ~system_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] pix(input int k);
    return PW'(k * 3 + 1);
  endfunction

  // Expected write stream and window sequence for one tile, raster order
  task automatic build_tile(input int w, input int h, input bit pad);
    int ew, eh, k;
    wr_t  e;
    win_t v;
    ew = pad ? w + 2 : w;
    eh = pad ? h + 2 : h;
    k  = 0;
    exp_wr.delete();
    exp_win.delete();
    for (int r = 0; r < eh; r++) begin
      for (int c = 0; c < ew; c++) begin
        e.pad = pad && (r == 0 || r == eh - 1 || c == 0 || c == ew - 1);
        if (e.pad) e.data = '0;
        else begin
          e.data = pix(k);
          k++;
        end
        exp_wr.push_back(e);
        if (r >= 2 && c >= 2) begin
          v.row = r;
          v.col = c;
          exp_win.push_back(v);
        end
      end
    end
  endtask

  // Runs one tile; toggle alternates out_ready 1,0,..; abort_after>0 clears after that many writes
  task automatic run_tile(input int w, input int h, input bit pad, input bit toggle, input int abort_after);
    int   idx, writes, wins, zeros, cyc, last_wr, ew, eh;
    bit   fin;
    wr_t  e;
    win_t v;
    idx = 0; writes = 0; wins = 0; zeros = 0; cyc = 0; last_wr = 0; fin = 1'b0;
    ew = pad ? w + 2 : w;
    eh = pad ? h + 2 : h;
    build_tile(w, h, pad);
    @(negedge system_clk);
    row_size  = DIM_W'(w);
    col_size  = DIM_W'(h);
    start     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge system_clk);
    start = 1'b0;
    check_eq("busy_run", busy, 1);
    check_eq("shift_size", sr_shift_size, 32'(ew - 2));
    check_eq("cfg_err_ok", cfg_err, 0);
    while (!fin) begin
      cyc++;
      if (window_valid) begin
        if (exp_win.size() == 0) check_eq("win_extra", window_valid, 0);
        else begin
          v = exp_win.pop_front();
          check_eq("win_row", win_row, v.row);
          check_eq("win_col", win_col, v.col);
        end
        wins++;
      end
      if (done) begin
        check_eq("done_latency", cyc - last_wr, 2);
        fin = 1'b1;
      end else if (cyc > 400) begin
        check_eq("timeout_cycles", cyc, 0);
        fin = 1'b1;
      end else begin
        out_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
        in_valid  = 1'b1;
        in_data   = pix(idx);
        if (abort_after > 0 && writes == abort_after) begin
          clear    = 1'b1;
          in_valid = 1'b0;
        end
        #1;
        if (!out_ready) check_eq("wr_on_stall", sr_wr_en, 0);
        if (sr_wr_en) begin
          if (exp_wr.size() == 0) check_eq("wr_extra", sr_wr_en, 0);
          else begin
            e = exp_wr.pop_front();
            check_eq("wr_data", sr_wr_data, e.data);
            check_eq("in_ready_slot", in_ready, !e.pad);
            if (e.pad) zeros++;
          end
          writes++;
          last_wr = cyc;
        end
        if (in_valid && in_ready) idx++;
        if (clear) begin
          @(negedge system_clk);
          clear    = 1'b0;
          in_valid = 1'b0;
          check_eq("abort_busy", busy, 0);
          check_eq("abort_done", done, 0);
          check_eq("abort_win", window_valid, 0);
          repeat (3) begin
            @(negedge system_clk);
            check_eq("abort_no_done", done, 0);
          end
          fin = 1'b1;
        end else begin
          @(negedge system_clk);
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (abort_after > 0) begin
      check_eq("abort_writes", writes, abort_after);
    end else begin
      check_eq("total_writes", writes, ew * eh);
      check_eq("total_windows", wins, (eh - 2) * (ew - 2));
      check_eq("zero_writes", zeros, pad ? (ew * eh - w * h) : 0);
      check_eq("win_leftover", exp_win.size(), 0);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge system_clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_wv", window_valid, 0);
    check_eq("rst_shift", sr_shift_size, 0);
    check_eq("rst_cfg", cfg_err, 0);
    rst_n = 1'b1;

    // Reset asserted in the middle of a tile
    @(negedge system_clk);
    row_size = 10'd5; col_size = 10'd4; start = 1'b1;
    @(negedge system_clk);
    start = 1'b0; in_valid = 1'b1; in_data = pix(0);
    repeat (4) @(negedge system_clk);
    check_eq("midrun_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_wr", sr_wr_en, 0);
    check_eq("midrst_wv", window_valid, 0);
    check_eq("midrst_done", done, 0);
    @(negedge system_clk);
    in_valid = 1'b0;
    rst_n = 1'b1;

    // Basic tile and the same tile under backpressure
    run_tile(5, 4, PAD, 1'b0, 0);
    run_tile(5, 4, PAD, 1'b1, 0);

    // Illegal size sets sticky cfg_err and stays idle
    @(negedge system_clk);
    row_size = PAD ? 10'd0 : 10'd2; col_size = 10'd4; start = 1'b1;
    @(negedge system_clk);
    start = 1'b0;
    check_eq("illegal_cfg", cfg_err, 1);
    check_eq("illegal_busy", busy, 0);
    repeat (2) @(negedge system_clk);
    check_eq("illegal_done", done, 0);
    check_eq("illegal_sticky", cfg_err, 1);
    run_tile(5, 4, PAD, 1'b0, 0);

    // Abort then restart with a smaller tile
    run_tile(5, 4, PAD, 1'b0, 7);
    run_tile(4, 3, PAD, 1'b0, 0);

`ifdef CONV_ZERO_PAD_EN
    // Smallest padded tile: 25 writes, 16 zero, 9 windows
    run_tile(3, 3, 1'b1, 1'b0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
